ct_biu_csr_mreq_arbiter: RTL and testbench
==========================================

CT_BIU_CSR_MREQ_ARBITER -- requirements
Module: ct_biu_csr_mreq_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2: number of CSR requesters, legal range 2..8; index 0 is cp0.
REQ-002 Parameter OP_W, default 16: CSR op width.
REQ-003 Parameter WDATA_W, default 64: write data width.
REQ-004 Parameter RDATA_W, default 128: read data width.
REQ-005 Parameter TO_CYCLES, default 1023: timeout limit in cycles, used only when timeout is compiled in.
REQ-006 forever_cpuclk  in  1  single clock; all state updates on the rising edge.
REQ-007 cpurst  in  1  reset, synchronous and active-high.
REQ-008 req_sel  in  NUM_REQ  per-requester request level; held until that requester's completion.
REQ-009 req_op  in  NUM_REQ*OP_W  per-requester op, packed, slice i = requester i.
REQ-010 req_wdata  in  NUM_REQ*WDATA_W  per-requester write data, packed.
REQ-011 req_cmplt  out  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-012 req_err  out  NUM_REQ  one-cycle timeout-error pulse, coincident with req_cmplt.
REQ-013 req_rdata  out  RDATA_W  read data broadcast to all requesters.
REQ-014 biu_csr_sel  out  1  request to the BIU CSR port.
REQ-015 biu_csr_op  out  OP_W  op to the BIU.
REQ-016 biu_csr_wdata  out  WDATA_W  write data to the BIU.
REQ-017 biu_csr_cmplt  in  1  BIU completion pulse.
REQ-018 biu_csr_rdata  in  RDATA_W  BIU read data, valid while biu_csr_cmplt is high.

Function
REQ-019 The arbiter SHALL use three states:
- IDLE: no grant held.
- BUSY: one grant held.
- GAP: one dead cycle, no grant.
REQ-020 IDLE with any req_sel high SHALL go to BUSY at the next edge.
- Grant register is set one-hot to the winner.
- biu_csr_op and biu_csr_wdata are registered from the winner's slices at that edge.
REQ-021 The winner SHALL be chosen round-robin: search starts at the index after the last-granted requester and wraps from NUM_REQ-1 to 0; the pointer resets to NUM_REQ-1, so requester 0 wins first.
REQ-022 biu_csr_sel SHALL be high exactly in BUSY.
- Latency: req_sel rising in IDLE gives biu_csr_sel on the next cycle.
- Op and wdata stay stable throughout BUSY.
REQ-023 In BUSY, req_cmplt[g] SHALL equal biu_csr_cmplt combinationally, where g is the granted index; req_rdata SHALL equal biu_csr_rdata.
REQ-024 biu_csr_cmplt in BUSY SHALL cause the transition to GAP; the round-robin pointer updates to g at the same edge.
REQ-025 GAP SHALL last one cycle, then go to IDLE; req_sel is ignored during GAP so the finished requester can drop its request.
REQ-026 biu_csr_cmplt in IDLE or GAP SHALL be ignored: no req_cmplt and no state change.
REQ-027 Outside BUSY, req_rdata, biu_csr_op and biu_csr_wdata SHALL read 0.
REQ-028 A requester that drops req_sel while granted SHALL NOT abort the transaction: the grant is held until completion or timeout.
REQ-029 Simultaneous requests SHALL be served strictly one at a time; no requester waits more than NUM_REQ-1 grants.

Reset
REQ-030 While cpurst is high at an edge, the following SHALL take these values:
- state: IDLE
- grant: 0
- rr pointer: NUM_REQ-1
- timeout counter: 0
- biu_csr_sel, biu_csr_op, biu_csr_wdata: 0
- req_cmplt, req_err, req_rdata: 0
REQ-031 Reset in BUSY SHALL drop the transaction silently; a later stray biu_csr_cmplt is ignored per REQ-026.

Configuration
REQ-032 With CT_BIU_CSR_ARB_TIMEOUT_EN defined, a counter of width clog2(TO_CYCLES+1) SHALL behave as follows:
- It clears on entry to BUSY and increments each BUSY cycle.
- It saturates at TO_CYCLES.
- If it equals TO_CYCLES without biu_csr_cmplt, req_cmplt[g] and req_err[g] pulse together with req_rdata 0, and the state goes to GAP.
- If biu_csr_cmplt arrives in that same cycle, it is a normal completion with req_err 0.
REQ-033 Without CT_BIU_CSR_ARB_TIMEOUT_EN, there SHALL be no counter; req_err is tied 0 and BUSY waits indefinitely.

Structure
REQ-034 A shared package ct_biu_csr_arb_pkg SHALL hold:
- the state enum (IDLE, BUSY, GAP);
- default parameter constants.
REQ-035 The round-robin picker SHALL be a sub-module ct_biu_csr_rr_pick: inputs are the request vector and pointer, output is the one-hot winner, purely combinational; all state stays in the parent.

Verification
REQ-036 Single request: req_sel=01, biu_csr_cmplt 3 cycles after grant with rdata=0xA5 -> the following occurs:
- biu_csr_sel high for 3 cycles, op = requester 0's op.
- req_cmplt=01 for one cycle with req_rdata=0xA5.
- Then one GAP cycle and a return to IDLE.
REQ-037 Contention, NUM_REQ=4, all req_sel held high -> grants in order 0,1,2,3,0 with exactly one GAP cycle between them.
REQ-038 Stray completion: biu_csr_cmplt pulsed in IDLE -> req_cmplt=0, state unchanged.
REQ-039 Reset mid-BUSY: assert cpurst for 1 cycle, then pulse biu_csr_cmplt -> biu_csr_sel=0, no req_cmplt, rr pointer=NUM_REQ-1.
REQ-040 Timeout, macro defined, TO_CYCLES=8, no biu_csr_cmplt -> req_cmplt and req_err pulse on the 9th BUSY cycle with req_rdata=0; a following request is served normally.
REQ-041 Timeout, macro undefined, same stimulus -> biu_csr_sel stays high and req_err stays 0.

Source files
------------

// File: rtl/ct_biu_csr_arb_pkg.sv
// Shared types and default sizing for the BIU CSR multi-requester arbiter.
// Holds the arbiter state encoding and the default parameter values.
package ct_biu_csr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_REQ   = 2;
    localparam int DEF_OP_W      = 16;
    localparam int DEF_WDATA_W   = 64;
    localparam int DEF_RDATA_W   = 128;
    localparam int DEF_TO_CYCLES = 1023;

endpackage

// File: rtl/ct_biu_csr_rr_pick.sv
// Round-robin picker: one-hot winner, searching from the index after ptr and wrapping.
// Purely combinational, zero latency; no state and no backpressure of its own.
module ct_biu_csr_rr_pick #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant
);

    logic found;

    // Offset i is the search distance from ptr; the first requesting index wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && req[j] && (((int'(ptr) + i) % NUM_REQ) == j)) begin
                    grant[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ct_biu_csr_mreq_arbiter.sv
// Arbitrates NUM_REQ CSR requesters onto one BIU CSR port, one transaction at a time (IDLE->BUSY->GAP).
// Grant one cycle after request; requesters wait on req_sel; optional timeout via CT_BIU_CSR_ARB_TIMEOUT_EN.
module ct_biu_csr_mreq_arbiter
    import ct_biu_csr_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int OP_W      = DEF_OP_W,
    parameter int WDATA_W   = DEF_WDATA_W,
    parameter int RDATA_W   = DEF_RDATA_W,
    parameter int TO_CYCLES = DEF_TO_CYCLES
) (
    input  logic                       forever_cpuclk,
    input  logic                       cpurst,
    input  logic [NUM_REQ-1:0]         req_sel,
    input  logic [NUM_REQ*OP_W-1:0]    req_op,
    input  logic [NUM_REQ*WDATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]         req_cmplt,
    output logic [NUM_REQ-1:0]         req_err,
    output logic [RDATA_W-1:0]         req_rdata,
    output logic                       biu_csr_sel,
    output logic [OP_W-1:0]            biu_csr_op,
    output logic [WDATA_W-1:0]         biu_csr_wdata,
    input  logic                       biu_csr_cmplt,
    input  logic [RDATA_W-1:0]         biu_csr_rdata
);

    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_e           state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, winner;
    logic [PTR_W-1:0]     gidx_q, ptr_q, win_idx;
    logic [OP_W-1:0]      op_q, win_op;
    logic [WDATA_W-1:0]   wdata_q, win_wdata;
    logic                 busy, start, done, timeout_hit, to_fire;

    ct_biu_csr_rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req   (req_sel),
        .ptr   (ptr_q),
        .grant (winner)
    );

    always_comb begin
        win_idx   = '0;
        win_op    = '0;
        win_wdata = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (winner[j]) begin
                win_idx   = PTR_W'(j);
                win_op    = req_op[j*OP_W +: OP_W];
                win_wdata = req_wdata[j*WDATA_W +: WDATA_W];
            end
        end
    end

    assign busy  = (state_q == BUSY);
    assign start = (state_q == IDLE) && (|req_sel);

`ifdef CT_BIU_CSR_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q;

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            to_cnt_q <= '0;
        end else if (start) begin
            to_cnt_q <= '0;
        end else if (busy && (to_cnt_q != TO_W'(TO_CYCLES))) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    assign timeout_hit = busy && (to_cnt_q == TO_W'(TO_CYCLES));
`else
    logic to_cycles_unused;
    assign to_cycles_unused = (TO_CYCLES != 0);
    assign timeout_hit      = 1'b0;
`endif

    // A real completion in the timeout cycle wins over the error.
    assign to_fire = timeout_hit && !biu_csr_cmplt;
    assign done    = busy && (biu_csr_cmplt || timeout_hit);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req_sel) state_d = BUSY;
            BUSY:    if (done)     state_d = GAP;
            GAP:                   state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= PTR_W'(NUM_REQ - 1);
            op_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                grant_q <= winner;
                gidx_q  <= win_idx;
                op_q    <= win_op;
                wdata_q <= win_wdata;
            end else if (done) begin
                grant_q <= '0;
                ptr_q   <= gidx_q;
                op_q    <= '0;
                wdata_q <= '0;
            end
        end
    end

    // grant_q, op_q and wdata_q are only non-zero in BUSY, so outputs need no extra state gating.
    assign biu_csr_sel   = busy;
    assign biu_csr_op    = op_q;
    assign biu_csr_wdata = wdata_q;
    assign req_cmplt     = {NUM_REQ{done}} & grant_q;
    assign req_err       = {NUM_REQ{to_fire}} & grant_q;
    assign req_rdata     = (busy && !to_fire) ? biu_csr_rdata : '0;

endmodule

// File: tb/tb_ct_biu_csr_mreq_arbiter.sv
// Directed bench for ct_biu_csr_mreq_arbiter with NUM_REQ=4 and TO_CYCLES=8.
module tb_ct_biu_csr_mreq_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int OP_W      = 16;
    localparam int WDATA_W   = 64;
    localparam int RDATA_W   = 128;
    localparam int TO_CYCLES = 8;

    logic                       forever_cpuclk = 1'b0;
    logic                       cpurst;
    logic [NUM_REQ-1:0]         req_sel;
    logic [NUM_REQ*OP_W-1:0]    req_op;
    logic [NUM_REQ*WDATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]         req_cmplt;
    logic [NUM_REQ-1:0]         req_err;
    logic [RDATA_W-1:0]         req_rdata;
    logic                       biu_csr_sel;
    logic [OP_W-1:0]            biu_csr_op;
    logic [WDATA_W-1:0]         biu_csr_wdata;
    logic                       biu_csr_cmplt;
    logic [RDATA_W-1:0]         biu_csr_rdata;

    ct_biu_csr_mreq_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .OP_W      (OP_W),
        .WDATA_W   (WDATA_W),
        .RDATA_W   (RDATA_W),
        .TO_CYCLES (TO_CYCLES)
    ) dut (
        .forever_cpuclk (forever_cpuclk),
        .cpurst         (cpurst),
        .req_sel        (req_sel),
        .req_op         (req_op),
        .req_wdata      (req_wdata),
        .req_cmplt      (req_cmplt),
        .req_err        (req_err),
        .req_rdata      (req_rdata),
        .biu_csr_sel    (biu_csr_sel),
        .biu_csr_op     (biu_csr_op),
        .biu_csr_wdata  (biu_csr_wdata),
        .biu_csr_cmplt  (biu_csr_cmplt),
        .biu_csr_rdata  (biu_csr_rdata)
    );

    always #5 forever_cpuclk = ~forever_cpuclk;

    typedef struct {
        logic         rst;
        logic [3:0]   sel;
        logic         cmplt;
        logic [127:0] rd;
        logic         e_sel;
        logic [15:0]  e_op;
        logic [63:0]  e_wd;
        logic [3:0]   e_cmplt;
        logic [3:0]   e_err;
        logic [127:0] e_rd;
    } vec_t;

    vec_t vt [16];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] s, input logic c, input logic [127:0] d);
        cpurst        = r;
        req_sel       = s;
        biu_csr_cmplt = c;
        biu_csr_rdata = d;
    endtask

    task automatic next_cycle();
        @(posedge forever_cpuclk);
        #1;
    endtask

    // Returns at the negedge of the first BUSY cycle; low counts the non-BUSY cycles seen first.
    task automatic wait_sel(output int low, output logic got);
        low = 0;
        got = 1'b0;
        for (int w = 0; w < 8; w++) begin
            @(negedge forever_cpuclk);
            if (biu_csr_sel) begin
                got = 1'b1;
                break;
            end
            low++;
            next_cycle();
        end
    endtask

    // Completes the current BUSY cycle, expecting the given requester mask, then lands in GAP.
    task automatic complete(input string name, input logic [3:0] mask, input logic [127:0] rd);
        biu_csr_cmplt = 1'b1;
        biu_csr_rdata = rd;
        #1;
        chk({name, "_cmplt"}, 128'(req_cmplt), 128'(mask));
        chk({name, "_err"},   128'(req_err),   128'(0));
        chk({name, "_rdata"}, req_rdata,       rd);
        next_cycle();
        biu_csr_cmplt = 1'b0;
        biu_csr_rdata = '0;
        req_sel       = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          low;
        logic        got;
        logic [3:0]  mask;
        int          exp_idx;

        for (int i = 0; i < NUM_REQ; i++) begin
            req_op[i*OP_W +: OP_W]          = 16'(16'hA0 + i);
            req_wdata[i*WDATA_W +: WDATA_W] = 64'(64'hD0 + i);
        end

        //          rst   sel      c     rd       e_sel  e_op    e_wd    e_cmplt  e_err  e_rd
        vt[0]  = '{1'b0, 4'b0000, 1'b0, 128'h55, 1'b0, 16'h00, 64'h00, 4'b0000, 4'b0, 128'h00};
        vt[1]  = '{1'b0, 4'b0001, 1'b0, 128'h00, 1'b0, 16'h00, 64'h00, 4'b0000, 4'b0, 128'h00};
        vt[2]  = '{1'b0, 4'b0001, 1'b0, 128'h11, 1'b1, 16'hA0, 64'hD0, 4'b0000, 4'b0, 128'h11};
        vt[3]  = '{1'b0, 4'b0001, 1'b0, 128'h22, 1'b1, 16'hA0, 64'hD0, 4'b0000, 4'b0, 128'h22};
        vt[4]  = '{1'b0, 4'b0001, 1'b1, 128'hA5, 1'b1, 16'hA0, 64'hD0, 4'b0001, 4'b0, 128'hA5};
        vt[5]  = '{1'b0, 4'b0000, 1'b1, 128'h77, 1'b0, 16'h00, 64'h00, 4'b0000, 4'b0, 128'h00};
        vt[6]  = '{1'b0, 4'b0000, 1'b1, 128'h33, 1'b0, 16'h00, 64'h00, 4'b0000, 4'b0, 128'h00};
        vt[7]  = '{1'b0, 4'b0000, 1'b0, 128'h00, 1'b0, 16'h00, 64'h00, 4'b0000, 4'b0, 128'h00};
        vt[8]  = '{1'b0, 4'b0011, 1'b0, 128'h00, 1'b0, 16'h00, 64'h00, 4'b0000, 4'b0, 128'h00};
        vt[9]  = '{1'b0, 4'b0011, 1'b1, 128'h5A, 1'b1, 16'hA1, 64'hD1, 4'b0010, 4'b0, 128'h5A};
        vt[10] = '{1'b0, 4'b0001, 1'b0, 128'h00, 1'b0, 16'h00, 64'h00, 4'b0000, 4'b0, 128'h00};
        vt[11] = '{1'b0, 4'b0001, 1'b0, 128'h00, 1'b0, 16'h00, 64'h00, 4'b0000, 4'b0, 128'h00};
        vt[12] = '{1'b0, 4'b0000, 1'b0, 128'h00, 1'b1, 16'hA0, 64'hD0, 4'b0000, 4'b0, 128'h00};
        vt[13] = '{1'b0, 4'b0000, 1'b1, 128'hC3, 1'b1, 16'hA0, 64'hD0, 4'b0001, 4'b0, 128'hC3};
        vt[14] = '{1'b0, 4'b0000, 1'b0, 128'h00, 1'b0, 16'h00, 64'h00, 4'b0000, 4'b0, 128'h00};
        vt[15] = '{1'b0, 4'b0000, 1'b0, 128'h00, 1'b0, 16'h00, 64'h00, 4'b0000, 4'b0, 128'h00};

        drive(1'b1, 4'b0000, 1'b0, '0);
        next_cycle();
        next_cycle();

        // Single request, stray completions, round-robin order and drop-while-granted.
        for (int i = 0; i < 16; i++) begin
            drive(vt[i].rst, vt[i].sel, vt[i].cmplt, vt[i].rd);
            @(negedge forever_cpuclk);
            chk($sformatf("v%0d_sel", i),   128'(biu_csr_sel),   128'(vt[i].e_sel));
            chk($sformatf("v%0d_op", i),    128'(biu_csr_op),    128'(vt[i].e_op));
            chk($sformatf("v%0d_wdata", i), 128'(biu_csr_wdata), 128'(vt[i].e_wd));
            chk($sformatf("v%0d_cmplt", i), 128'(req_cmplt),     128'(vt[i].e_cmplt));
            chk($sformatf("v%0d_err", i),   128'(req_err),       128'(vt[i].e_err));
            chk($sformatf("v%0d_rdata", i), req_rdata,           vt[i].e_rd);
            next_cycle();
        end

        // Contention: all four held high, grants must go 0,1,2,3,0 with GAP+IDLE between.
        drive(1'b1, 4'b0000, 1'b0, '0);
        next_cycle();
        drive(1'b0, 4'b1111, 1'b0, '0);
        for (int g = 0; g < 5; g++) begin
            exp_idx = g % NUM_REQ;
            mask    = 4'b0001 << exp_idx;
            wait_sel(low, got);
            chk($sformatf("cont%0d_grant", g), 128'(got), 128'(1));
            if (g > 0) chk($sformatf("cont%0d_gap", g), 128'(low), 128'(2));
            chk($sformatf("cont%0d_op", g), 128'(biu_csr_op), 128'(16'hA0 + exp_idx));
            biu_csr_cmplt = 1'b1;
            #1;
            chk($sformatf("cont%0d_cmplt", g), 128'(req_cmplt), 128'(mask));
            next_cycle();
            biu_csr_cmplt = 1'b0;
        end

        // Reset mid-BUSY: pointer is 0 here, so requester 1 wins, then reset drops it.
        req_sel = 4'b0010;
        wait_sel(low, got);
        chk("rst_pre_grant", 128'(got), 128'(1));
        chk("rst_pre_op", 128'(biu_csr_op), 128'(16'hA1));
        next_cycle();
        drive(1'b1, 4'b0000, 1'b0, '0);
        next_cycle();
        drive(1'b0, 4'b0000, 1'b1, 128'hEE);
        @(negedge forever_cpuclk);
        chk("rst_stray_sel", 128'(biu_csr_sel), 128'(0));
        chk("rst_stray_cmplt", 128'(req_cmplt), 128'(0));
        chk("rst_stray_rdata", req_rdata, 128'(0));
        next_cycle();
        drive(1'b0, 4'b0011, 1'b0, '0);
        wait_sel(low, got);
        chk("rst_ptr_grant", 128'(got), 128'(1));
        chk("rst_ptr_op", 128'(biu_csr_op), 128'(16'hA0));
        complete("rst_post", 4'b0001, 128'h42);

        // Timeout on requester 2 with a silent BIU.
        req_sel       = 4'b0100;
        biu_csr_rdata = 128'hFF;
        wait_sel(low, got);
        chk("to_grant", 128'(got), 128'(1));
`ifdef CT_BIU_CSR_ARB_TIMEOUT_EN
        for (int n = 1; n < 9; n++) begin
            chk($sformatf("to_busy%0d_cmplt", n), 128'(req_cmplt), 128'(0));
            chk($sformatf("to_busy%0d_sel", n), 128'(biu_csr_sel), 128'(1));
            next_cycle();
            @(negedge forever_cpuclk);
        end
        chk("to_fire_cmplt", 128'(req_cmplt), 128'(4'b0100));
        chk("to_fire_err", 128'(req_err), 128'(4'b0100));
        chk("to_fire_rdata", req_rdata, 128'(0));
        next_cycle();
        req_sel = '0;
        @(negedge forever_cpuclk);
        chk("to_gap_sel", 128'(biu_csr_sel), 128'(0));
        next_cycle();
        req_sel = 4'b1000;
        wait_sel(low, got);
        chk("to_next_grant", 128'(got), 128'(1));
        chk("to_next_op", 128'(biu_csr_op), 128'(16'hA3));
        complete("to_next", 4'b1000, 128'h99);
`else
        for (int n = 1; n <= 20; n++) begin
            chk($sformatf("noto_busy%0d_sel", n), 128'(biu_csr_sel), 128'(1));
            chk($sformatf("noto_busy%0d_err", n), 128'(req_err), 128'(0));
            chk($sformatf("noto_busy%0d_cmplt", n), 128'(req_cmplt), 128'(0));
            next_cycle();
            @(negedge forever_cpuclk);
        end
        complete("noto_end", 4'b0100, 128'h99);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
